// File: rtl/bank_burst_ctrl.sv
// Cycle-level model of one DRAM bank behind an ACT/RD/WR/PRE command port:
// open-row tracking, tRCD/tRP/CL timing and BL-beat wrapped bursts.
module bank_burst_ctrl #(
  parameter int unsigned DEVICE_WIDTH = 4,
  parameter int unsigned COLS         = 1024,
  parameter int unsigned ROWS         = 32,
  parameter int unsigned BL           = 8,
  parameter int unsigned CL           = 3,
  parameter int unsigned TRCD         = 2,
  parameter int unsigned TRP          = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [2:0]                cmd,
  input  logic [$clog2(ROWS)-1:0]   row,
  input  logic [$clog2(COLS)-1:0]   column,
  input  logic [DEVICE_WIDTH-1:0]   dqin,
  output logic [DEVICE_WIDTH-1:0]   dqout,
  output logic                      dq_valid,
  output logic                      row_open,
  output logic [$clog2(ROWS)-1:0]   open_row,
  output logic                      err
);

  localparam int unsigned RW    = $clog2(ROWS);
  localparam int unsigned CLW   = $clog2(COLS);
  localparam int unsigned BW    = $clog2(BL);
  localparam int unsigned T_RD  = CL + BL;
  localparam int unsigned T_MAX = (TRCD > TRP) ? ((TRCD > T_RD) ? TRCD : T_RD)
                                               : ((TRP  > T_RD) ? TRP  : T_RD);
  localparam int unsigned CNTW  = $clog2(T_MAX + 1);

  localparam logic [2:0] CMD_ACT = 3'd1;
  localparam logic [2:0] CMD_RD  = 3'd2;
  localparam logic [2:0] CMD_WR  = 3'd3;
  localparam logic [2:0] CMD_PRE = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACTIVATING,
    S_ACTIVE,
    S_WRITING,
    S_READ_WAIT,
    S_READING,
    S_PRECHARGING
  } state_t;

  state_t                  state_q, state_d;
  logic [CNTW-1:0]         cnt_q, cnt_d;
  logic [CLW-1:0]          col_q, col_d;
  logic [DEVICE_WIDTH-1:0] dqout_d;
  logic                    dq_valid_d;
  logic                    row_open_d;
  logic [RW-1:0]           open_row_d;
  logic                    err_d;

  logic                    accept;
  logic [BW-1:0]           beat_off;
  logic [CLW-1:0]          beat_col;
  logic [CLW-1:0]          wr_col;
  logic                    mem_we;
  logic [DEVICE_WIDTH-1:0] rd_data;

  // 2-state storage starts at zero and is deliberately left out of reset.
  bit [DEVICE_WIDTH-1:0]   mem [ROWS][COLS];

  assign cmd_ready = (state_q == S_IDLE) || (state_q == S_ACTIVE);
  assign accept    = cmd_valid && cmd_ready;

  // Wrap inside the BL-aligned block: the offset add is BW bits wide.
  assign beat_off  = BW'(col_q) + BW'(cnt_q);
  assign beat_col  = (col_q & ~CLW'(BL - 1)) | CLW'(beat_off);
  assign rd_data   = mem[open_row][beat_col];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    col_d      = col_q;
    dqout_d    = dqout;
    dq_valid_d = 1'b0;
    row_open_d = row_open;
    open_row_d = open_row;
    err_d      = 1'b0;
    mem_we     = 1'b0;
    wr_col     = beat_col;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (cmd)
            CMD_ACT: begin
              open_row_d = row;
              cnt_d      = CNTW'(TRCD - 1);
              state_d    = S_ACTIVATING;
            end
            CMD_RD, CMD_WR: err_d = 1'b1;
            default: ;
          endcase
        end
      end

      S_ACTIVATING: begin
        if (cnt_q == '0) begin
          row_open_d = 1'b1;
          state_d    = S_ACTIVE;
        end else begin
          cnt_d = cnt_q - CNTW'(1);
        end
      end

      S_ACTIVE: begin
        if (accept) begin
          case (cmd)
            CMD_WR: begin
              // Beat 0 lands on the accept edge at the start column itself.
              col_d   = column;
              wr_col  = column;
              mem_we  = 1'b1;
              cnt_d   = CNTW'(1);
              state_d = S_WRITING;
            end
            CMD_RD: begin
              col_d   = column;
              cnt_d   = CNTW'(CL - 1);
              state_d = S_READ_WAIT;
            end
            CMD_PRE: begin
              row_open_d = 1'b0;
              cnt_d      = CNTW'(TRP - 1);
              state_d    = S_PRECHARGING;
            end
            CMD_ACT: err_d = 1'b1;
            default: ;
          endcase
        end
      end

      S_WRITING: begin
        mem_we = 1'b1;
        if (cnt_q == CNTW'(BL - 1)) begin
          cnt_d   = '0;
          state_d = S_ACTIVE;
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end

      S_READ_WAIT: begin
        if (cnt_q == '0) begin
          dqout_d    = rd_data;
          dq_valid_d = 1'b1;
          cnt_d      = CNTW'(1);
          state_d    = S_READING;
        end else begin
          cnt_d = cnt_q - CNTW'(1);
        end
      end

      S_READING: begin
        if (cnt_q == CNTW'(BL)) begin
          cnt_d   = '0;
          state_d = S_ACTIVE;
        end else begin
          dqout_d    = rd_data;
          dq_valid_d = 1'b1;
          cnt_d      = cnt_q + CNTW'(1);
        end
      end

      S_PRECHARGING: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CNTW'(1);
        end
      end

      default: begin
        state_d    = S_IDLE;
        cnt_d      = '0;
        row_open_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      col_q    <= '0;
      dqout    <= '0;
      dq_valid <= 1'b0;
      row_open <= 1'b0;
      open_row <= '0;
      err      <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      col_q    <= col_d;
      dqout    <= dqout_d;
      dq_valid <= dq_valid_d;
      row_open <= row_open_d;
      open_row <= open_row_d;
      err      <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[open_row][wr_col] <= dqin;
    end
  end

endmodule

// File: tb/tb_bank_burst_ctrl.sv
// Scoreboard bench for bank_burst_ctrl: directed scenarios plus random
// command traffic checked against an array-based bank model.
module tb_bank_burst_ctrl;

  localparam int DW   = 4;
  localparam int COLS = 1024;
  localparam int ROWS = 32;
  localparam int BL   = 8;
  localparam int CL   = 3;
  localparam int TRCD = 2;
  localparam int TRP  = 2;
  localparam int RW   = $clog2(ROWS);
  localparam int CW   = $clog2(COLS);

  localparam logic [2:0] C_NOP = 3'd0;
  localparam logic [2:0] C_ACT = 3'd1;
  localparam logic [2:0] C_RD  = 3'd2;
  localparam logic [2:0] C_WR  = 3'd3;
  localparam logic [2:0] C_PRE = 3'd4;

  typedef struct {
    int data;
    int cyc;
  } beat_t;

  logic          clk       = 1'b0;
  logic          rst_n     = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [2:0]    cmd       = 3'd0;
  logic [RW-1:0] row       = '0;
  logic [CW-1:0] column    = '0;
  logic [DW-1:0] dqin      = '0;
  logic [DW-1:0] dqout;
  logic          dq_valid;
  logic          row_open;
  logic [RW-1:0] open_row;
  logic          err;

  int    cyc    = 0;
  int    checks = 0;
  int    errors = 0;
  beat_t rd_q[$];
  int    err_q[$];

  // Reference bank: contents, plus whether a row is open and which.
  bit [DW-1:0] model_mem [ROWS][COLS];
  bit          m_open = 1'b0;
  int          m_row  = 0;

  bank_burst_ctrl #(
    .DEVICE_WIDTH(DW), .COLS(COLS), .ROWS(ROWS), .BL(BL),
    .CL(CL), .TRCD(TRCD), .TRP(TRP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd(cmd), .row(row), .column(column), .dqin(dqin), .dqout(dqout),
    .dq_valid(dq_valid), .row_open(row_open), .open_row(open_row), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Column touched by beat i of a burst starting at col.
  function automatic int burst_col(input int col, input int i);
    return (col - col % BL) + (col + i) % BL;
  endfunction

  // Monitor: consume expected read beats and err pulses as the DUT shows them.
  always @(negedge clk) begin
    beat_t e;
    if (dq_valid) begin
      if (rd_q.size() == 0) begin
        check("unexpected_dq_valid", 1, 0);
      end else begin
        e = rd_q.pop_front();
        check("rd_data", int'(dqout), e.data);
        check("rd_cycle", cyc, e.cyc);
      end
    end
    if (err) begin
      if (err_q.size() == 0) check("unexpected_err", 1, 0);
      else                   check("err_cycle", cyc, err_q.pop_front());
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a command once the bank is ready; n returns the accept edge.
  task automatic send(input logic [2:0] c, input int r, input int col, output int n);
    int g;
    g = 0;
    while (!cmd_ready && g < 64) begin
      tick();
      g++;
    end
    if (!cmd_ready) check("ready_timeout", 0, 1);
    cmd_valid = 1'b1;
    cmd       = c;
    row       = RW'(r);
    column    = CW'(col);
    tick();
    n         = cyc;
    cmd_valid = 1'b0;
    cmd       = C_NOP;
  endtask

  // Wait for cmd_ready; optionally hold an ACT on the bus while busy.
  task automatic wait_ready(input int n, input int expd, input string name, input bit hold);
    while (!cmd_ready && cyc - n < 64) begin
      if (hold && (cyc - n < expd - 1)) begin
        cmd_valid = 1'b1;
        cmd       = C_ACT;
      end else begin
        cmd_valid = 1'b0;
        cmd       = C_NOP;
      end
      tick();
    end
    cmd_valid = 1'b0;
    cmd       = C_NOP;
    check(name, cyc - n, expd);
  endtask

  task automatic do_act(input int r);
    int n;
    bit was_open;
    was_open = m_open;
    send(C_ACT, r, 0, n);
    if (was_open) begin
      err_q.push_back(n);
      check("act_keeps_open_row", int'(open_row), m_row);
      check("act_keeps_row_open", int'(row_open), 1);
    end else begin
      m_open = 1'b1;
      m_row  = r;
      check("activating_row_closed", int'(row_open), 0);
      wait_ready(n, TRCD, "act_to_active", 1'b0);
      check("row_open_after_trcd", int'(row_open), 1);
      check("open_row_latched", int'(open_row), r);
    end
  endtask

  task automatic do_rd(input int col, input bit hold);
    int    n;
    beat_t b;
    int    last;
    last = 0;
    send(C_RD, 0, col, n);
    if (!m_open) begin
      err_q.push_back(n);
    end else begin
      for (int i = 0; i < BL; i++) begin
        b.data = int'(model_mem[m_row][burst_col(col, i)]);
        b.cyc  = n + CL + i;
        rd_q.push_back(b);
        last = b.data;
      end
      wait_ready(n, CL + BL, "rd_to_active", hold);
      check("rd_drained", rd_q.size(), 0);
      check("dqout_holds_last", int'(dqout), last);
      check("dq_valid_dropped", int'(dq_valid), 0);
    end
  endtask

  task automatic do_wr(input int col, input logic [DW-1:0] d [BL]);
    int n;
    dqin = d[0];
    send(C_WR, 0, col, n);
    if (!m_open) begin
      err_q.push_back(n);
    end else begin
      for (int i = 1; i < BL; i++) begin
        if (i == BL - 1) check("wr_busy", int'(cmd_ready), 0);
        dqin = d[i];
        tick();
      end
      check("wr_ready_after_burst", int'(cmd_ready), 1);
      for (int i = 0; i < BL; i++) model_mem[m_row][burst_col(col, i)] = d[i];
    end
  endtask

  task automatic do_pre();
    int n;
    send(C_PRE, 0, 0, n);
    if (m_open) begin
      check("pre_drops_row_open", int'(row_open), 0);
      m_open = 1'b0;
      wait_ready(n, TRP, "pre_to_idle", 1'b0);
    end else begin
      check("pre_idle_no_err", int'(err), 0);
    end
  endtask

  task automatic do_nop(input logic [2:0] c);
    int n;
    send(c, 0, 0, n);
  endtask

  initial begin
    logic [DW-1:0] d [BL];
    beat_t         b;
    int            n;
    int            k;
    int            v;

    // Reset values
    repeat (2) tick();
    check("reset_dqout", int'(dqout), 0);
    check("reset_dq_valid", int'(dq_valid), 0);
    check("reset_row_open", int'(row_open), 0);
    check("reset_open_row", int'(open_row), 0);
    check("reset_err", int'(err), 0);
    check("reset_ready", int'(cmd_ready), 1);
    rst_n = 1'b1;
    tick();
    check("idle_ready", int'(cmd_ready), 1);
    check("idle_row_open", int'(row_open), 0);

    // Basic write/read on row 1, read held against an ACT on the bus
    do_act(1);
    for (int i = 0; i < BL; i++) d[i] = DW'(i + 1);
    do_wr(0, d);
    do_rd(0, 1'b1);
    do_pre();

    // Wrapped bursts
    do_act(1);
    do_rd(5, 1'b0);
    for (int i = 0; i < BL; i++) d[i] = DW'($urandom);
    do_wr(13, d);
    do_rd(8, 1'b0);
    do_rd(13, 1'b0);

    // Illegal commands, including back-to-back illegal ACTs
    do_pre();
    do_rd(0, 1'b0);
    do_wr(0, d);
    do_pre();
    do_act(1);
    do_act(3);
    do_act(3);
    do_pre();

    // Row isolation and unwritten row
    for (int i = 0; i < BL; i++) d[i] = 4'hA;
    do_act(1); do_wr(0, d); do_pre();
    for (int i = 0; i < BL; i++) d[i] = 4'h5;
    do_act(2); do_wr(0, d); do_pre();
    do_act(1); do_rd(0, 1'b0); do_pre();
    do_act(2); do_rd(0, 1'b0); do_pre();
    do_act(7); do_rd(0, 1'b0); do_pre();

    // Reset in the middle of a read burst, then reread
    for (int i = 0; i < BL; i++) d[i] = DW'(15 - i);
    do_act(1); do_wr(0, d);
    send(C_RD, 0, 0, n);
    for (int i = 0; i < BL; i++) begin
      b.data = int'(model_mem[m_row][burst_col(0, i)]);
      b.cyc  = n + CL + i;
      rd_q.push_back(b);
    end
    while (cyc < n + CL + 2) tick();
    #6;
    rst_n = 1'b0;
    #1;
    check("midrst_dq_valid", int'(dq_valid), 0);
    check("midrst_dqout", int'(dqout), 0);
    check("midrst_row_open", int'(row_open), 0);
    check("midrst_open_row", int'(open_row), 0);
    check("midrst_ready", int'(cmd_ready), 1);
    check("midrst_beats_seen", rd_q.size(), BL - 3);
    rd_q.delete();
    m_open = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    check("post_rst_ready", int'(cmd_ready), 1);
    check("post_rst_row_open", int'(row_open), 0);
    do_act(1);
    do_rd(0, 1'b0);

    // Random traffic over a small address window
    for (int it = 0; it < 120; it++) begin
      k = int'($urandom_range(0, 9));
      case (k)
        0, 1: do_act(int'($urandom_range(0, 3)));
        2, 3: do_rd(int'($urandom_range(0, 31)), 1'(m_open && ($urandom_range(0, 1) == 1)));
        4, 5: begin
          for (int i = 0; i < BL; i++) d[i] = DW'($urandom);
          do_wr(int'($urandom_range(0, 31)), d);
        end
        6: do_pre();
        7: begin
          v = int'($urandom_range(0, 3));
          do_nop((v == 0) ? C_NOP : 3'(4 + v));
        end
        default: if (!m_open) do_act(int'($urandom_range(0, 3)));
                 else do_rd(int'($urandom_range(0, 31)), 1'b0);
      endcase
    end

    repeat (4) tick();
    check("rd_queue_empty", rd_q.size(), 0);
    check("err_queue_empty", err_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bank_burst_ctrl.md
Name: bank_burst_ctrl

Overview:
- Cycle-level behavioural model of one DRAM bank with an explicit command interface: ACT, RD, WR, PRE.
- Parametrised successor to the plain per-cycle read/write bank model. Adds:
  - an open-row state machine;
  - tRCD / tRP / CL timing counters;
  - BL-beat bursts with wrap-around column sequencing;
  - illegal-command detection.
- Sits under the rank/channel model; one instance per bank.

Parameters:
- DEVICE_WIDTH, 4, dq width per device in bits.
- COLS, 1024, columns per row; must be a multiple of BL.
- ROWS, 32, rows per bank.
- BL, 8, burst length in beats; power of two, at least 2.
- CL, 3, read latency in clocks from RD accept to first data; at least 1.
- TRCD, 2, clocks from ACT accept to ACTIVE; at least 1.
- TRP, 2, clocks from PRE accept to IDLE; at least 1.

Ports:
- clk, in, 1, clock; all state updates on its rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- cmd_valid, in, 1, command present.
- cmd_ready, out, 1, bank can accept a command this cycle.
- cmd, in, 3, command code: 0 NOP, 1 ACT, 2 RD, 3 WR, 4 PRE; 5-7 are treated as NOP.
- row, in, $clog2(ROWS), row address; sampled on ACT accept.
- column, in, $clog2(COLS), starting column; sampled on RD/WR accept.
- dqin, in, DEVICE_WIDTH, write data, one beat per cycle.
- dqout, out, DEVICE_WIDTH, read data.
- dq_valid, out, 1, dqout holds a valid read beat.
- row_open, out, 1, bank is ACTIVE with a row open.
- open_row, out, $clog2(ROWS), currently open row.
- err, out, 1, one-cycle pulse on an illegal command.

Behaviour:

Reset (asynchronous, rst_n low):
- State goes to IDLE.
- dqout=0, dq_valid=0, row_open=0, open_row=0, err=0.
- All counters are cleared.
- The storage array is not cleared: it is zero-initialised at time 0 only, and contents survive reset.

Handshake:
- A command is accepted when cmd_valid and cmd_ready are both high on a rising edge.
- cmd_ready is combinational: high only in IDLE and ACTIVE.

States and transitions:
- IDLE:
  - ACT: latch row into open_row, enter ACTIVATING.
  - PRE, NOP: no effect, no err.
  - RD, WR: err pulse; command ignored.
- ACTIVATING:
  - Lasts TRCD cycles, then enters ACTIVE.
  - row_open rises on the ACTIVE entry edge, i.e. TRCD edges after the accept edge.
- ACTIVE:
  - WR: enter WRITING.
  - RD: enter READ_WAIT.
  - PRE: row_open drops on the accept edge; enter PRECHARGING.
  - ACT: err pulse; open_row unchanged.
  - NOP: stay.
- WRITING:
  - Beat 0 of dqin is sampled on the accept edge.
  - Beats 1..BL-1 are sampled on the following BL-1 edges.
  - Each beat is stored on the edge that samples it.
  - Returns to ACTIVE on the edge that samples the last beat.
- READ_WAIT, then READING:
  - Beat i is driven on dqout with dq_valid=1 for exactly one cycle, starting at edge accept+CL+i, for i=0..BL-1.
  - Returns to ACTIVE on the edge that drops dq_valid.
  - dqout holds its last value while dq_valid=0.
- PRECHARGING:
  - Lasts TRP cycles, then enters IDLE.

Burst addressing (sequential wrap within the BL-aligned block):
- base = column with its low log2(BL) bits cleared.
- Beat i addresses base + ((column + i) mod BL).
- The low bits of column select the start beat; a burst never crosses its aligned block.

err:
- Registered; high for the one cycle after the illegal accept edge, then 0.
- Back-to-back illegal commands give back-to-back pulses.

Other rules:
- A read of a location never written returns 0.
- Width rules:
  - Counters are $clog2(max(TRCD,TRP,CL+BL)+1) bits wide.
  - Address arithmetic is done in $clog2(BL) bits, so the wrap is free.
- Reset mid-burst:
  - A write burst is truncated; beats already stored stay stored.
  - A read burst stops; dq_valid=0 immediately.
  - Either way the bank returns to IDLE with row_open=0.
- cmd_valid held high while cmd_ready is low has no effect and causes no err.

Test Plan:
1. Reset: assert rst_n=0 mid-cycle → outputs go to zero asynchronously and cmd_ready=1. Release → still IDLE.
2. Basic write/read (row=1, TRCD=2, CL=3):
   - ACT row=1 → row_open=1 two edges after accept.
   - WR column=0 with dqin=1..8 → cmd_ready low for 7 cycles.
   - RD column=0 → dq_valid high on edges accept+3..+10 with dqout=1..8.
   - PRE → row_open=0 on the accept edge; cmd_ready=1 again after 2 cycles.
3. Wrap: with columns 0..7 holding 1..8, RD column=5 → dqout sequence 6,7,8,1,2,3,4,5. WR column=13 writes columns 13,14,15,8,9,10,11,12.
4. Illegal commands:
   - RD in IDLE → err=1 for one cycle, no dq_valid.
   - ACT row=3 while row 1 is open → err=1, open_row stays 1.
   - PRE in IDLE → err stays 0.
5. Row isolation: write 0xA at row 1 column 0 and 0x5 at row 2 column 0, each via ACT/WR/PRE → reading back returns 0xA and 0x5 respectively. An unwritten row reads 0.
6. Reset during read after beat 2 → dq_valid=0 at once. Re-ACT and re-read → full original data, proving the array is preserved.
